// File: rtl/rtc_bus_responder.sv
// Byte-wide multiplexed-bus slave for a BCD real-time clock: synchronized strobe
// decoding, address latch, read driver, one-second prescaler and time/timer registers.
module rtc_bus_responder #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_d,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  inout  wire  [7:0] dato,
  output logic [7:0] out_addr,
  output logic       evento_escritura,
  output logic       error_protocolo
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Synchronizer word: {valid, cs, a_d, rd, wr, dato}; valid marks when stage 2
  // first holds real bus samples after reset rather than the idle reset pattern.
  localparam logic [12:0] SYNC_IDLE = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};

  logic [12:0]   sync1, sync2;
  logic          s_valid, s_cs, s_ad, s_rd, s_wr;
  logic [7:0]    s_dato;
  logic          p_cs, p_ad, p_wr;
  logic [7:0]    p_dato;
  logic          armed, wr_abort, err_q;
  logic          drive_en;
  logic [7:0]    rd_data, reg_rd;
  logic [PW-1:0] presc;
  logic [7:0]    sec, min, hour, day, mon, year, tsec, tmin, thour;
  logic          wr_rise, commit, commit_addr, commit_data;
  logic          err_cond, read_active, tick, addr_writable;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_inc = (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
    end else begin
      sync1 <= {1'b1, cs, a_d, rd, wr, dato};
      sync2 <= sync1;
    end
  end

  assign {s_valid, s_cs, s_ad, s_rd, s_wr, s_dato} = sync2;

  // The p_* copies hold the bus as seen in the last wr-low cycle when wr rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_cs   <= 1'b1;
      p_ad   <= 1'b0;
      p_wr   <= 1'b1;
      p_dato <= 8'h00;
    end else begin
      p_cs   <= s_cs;
      p_ad   <= s_ad;
      p_wr   <= s_wr;
      p_dato <= s_dato;
    end
  end

  always_comb begin
    addr_writable = 1'b0;
    case (out_addr)
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
      8'h41, 8'h42, 8'h43: addr_writable = 1'b1;
      default:             addr_writable = 1'b0;
    endcase
  end

  assign wr_rise     = s_wr && !p_wr;
  assign commit      = wr_rise && armed && !wr_abort && !p_cs;
  assign commit_addr = commit && !p_ad;
  assign commit_data = commit && p_ad && addr_writable;
  assign err_cond    = s_valid && !s_cs && !s_rd && !s_wr;
  assign read_active = s_valid && !s_cs && s_ad && !s_rd && s_wr;
  assign tick        = (presc == PRESC_MAX);

  // armed only goes high once a real idle wr has been seen, so a strobe that
  // straddles reset can never commit; wr_abort kills a strobe that saw rd+wr low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed            <= 1'b0;
      wr_abort         <= 1'b0;
      err_q            <= 1'b0;
      error_protocolo  <= 1'b0;
      evento_escritura <= 1'b0;
    end else begin
      armed            <= armed | (s_valid & s_wr);
      err_q            <= err_cond;
      error_protocolo  <= err_cond && !err_q;
      evento_escritura <= commit_data;
      if (err_cond)     wr_abort <= 1'b1;
      else if (wr_rise) wr_abort <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           out_addr <= 8'h00;
    else if (commit_addr) out_addr <= p_dato;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // A committed data write takes priority and the coincident tick is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec  <= 8'h00; min  <= 8'h00; hour  <= 8'h00;
      day  <= 8'h00; mon  <= 8'h00; year  <= 8'h00;
      tsec <= 8'h00; tmin <= 8'h00; thour <= 8'h00;
    end else if (commit_data) begin
      case (out_addr)
        8'h21:   sec   <= p_dato;
        8'h22:   min   <= p_dato;
        8'h23:   hour  <= p_dato;
        8'h24:   day   <= p_dato;
        8'h25:   mon   <= p_dato;
        8'h26:   year  <= p_dato;
        8'h41:   tsec  <= p_dato;
        8'h42:   tmin  <= p_dato;
        8'h43:   thour <= p_dato;
        default: ;
      endcase
    end else if (tick) begin
      if (sec == 8'h59) begin
        sec <= 8'h00;
        if (min == 8'h59) begin
          min  <= 8'h00;
          hour <= (hour == 8'h23) ? 8'h00 : bcd_inc(hour);
        end else begin
          min <= bcd_inc(min);
        end
      end else begin
        sec <= bcd_inc(sec);
      end
    end
  end

  always_comb begin
    reg_rd = 8'h00;
    case (out_addr)
      8'h21:   reg_rd = sec;
      8'h22:   reg_rd = min;
      8'h23:   reg_rd = hour;
      8'h24:   reg_rd = day;
      8'h25:   reg_rd = mon;
      8'h26:   reg_rd = year;
      8'h41:   reg_rd = tsec;
      8'h42:   reg_rd = tmin;
      8'h43:   reg_rd = thour;
      default: reg_rd = 8'h00;
    endcase
  end

  // Read data is captured once at strobe start so the bus stays stable even if
  // the clock ticks mid-read; drive drops as soon as the synchronized strobe ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drive_en <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      drive_en <= read_active;
      if (read_active && !drive_en) rd_data <= reg_rd;
    end
  end

  assign dato = (drive_en && read_active) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder; a pull-up on the bus makes a released
// dato read as 8'hFF, and cyc mirrors the prescaler phase for tick alignment.
module tb_rtc_bus_responder;

  localparam int TD = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_d = 1'b0, cs = 1'b1, rd = 1'b1, wr = 1'b1;
  logic       tb_drive = 1'b0;
  logic [7:0] tb_dato = 8'h00;
  wire  [7:0] dato;
  logic [7:0] out_addr;
  logic       evento_escritura, error_protocolo;
  logic [7:0] scratch;
  int         errors = 0, checks = 0, ev_cnt = 0, err_cnt = 0, cyc = 0;

  assign dato = tb_drive ? tb_dato : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (dato[i]);
  end

  rtc_bus_responder #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .dato(dato), .out_addr(out_addr),
    .evento_escritura(evento_escritura), .error_protocolo(error_protocolo)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (evento_escritura) ev_cnt++;
    if (error_protocolo)  err_cnt++;
  end

  task automatic bus_write(input logic ad, input logic [7:0] d, output logic [7:0] addr_seen);
    cs = 1'b0; a_d = ad; tb_dato = d; tb_drive = 1'b1; wr = 1'b0;
    repeat (5) @(negedge clk);
    wr = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b1; a_d = 1'b0; tb_drive = 1'b0;
    @(negedge clk);
    addr_seen = out_addr;
    @(negedge clk);
  endtask

  task automatic set_addr(input logic [7:0] a);
    bus_write(1'b0, a, scratch);
  endtask

  task automatic write_data(input logic [7:0] d);
    bus_write(1'b1, d, scratch);
  endtask

  task automatic bus_read(output logic [7:0] first, output bit stable, output logic [7:0] released);
    stable = 1'b1;
    first  = 8'h00;
    cs = 1'b0; a_d = 1'b1; rd = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) first = dato;
      else if (i > 3 && dato !== first) stable = 1'b0;
    end
    rd = 1'b1;
    repeat (3) @(negedge clk);
    released = dato;
    cs = 1'b1; a_d = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
    bit         st;
    logic [7:0] rel;
    set_addr(a);
    bus_read(v, st, rel);
  endtask

  task automatic wait_phase(input int ph);
    while ((cyc % TD) != ph) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; a_d = 1'b0; tb_drive = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_addr got=%h exp=00", out_addr); end
    checks++; if (evento_escritura !== 1'b0) begin errors++; $display("[TB] FAIL reset_evento got=%b exp=0", evento_escritura); end
    checks++; if (error_protocolo !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got=%b exp=0", error_protocolo); end
    checks++; if (dato !== 8'hFF) begin errors++; $display("[TB] FAIL reset_bus_released got=%h exp=ff", dato); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_addr_write();
    int ev0;
    logic [7:0] seen;
    ev0 = ev_cnt;
    bus_write(1'b0, 8'h22, seen);
    checks++; if (seen !== 8'h22) begin errors++; $display("[TB] FAIL addr_latch got=%h exp=22", seen); end
    checks++; if (ev_cnt - ev0 !== 0) begin errors++; $display("[TB] FAIL addr_no_event got=%0d exp=0", ev_cnt - ev0); end
  endtask

  task automatic test_data_write_read();
    int ev0;
    logic [7:0] v, rel;
    bit st;
    ev0 = ev_cnt;
    write_data(8'h45);
    checks++; if (ev_cnt - ev0 !== 1) begin errors++; $display("[TB] FAIL data_event_count got=%0d exp=1", ev_cnt - ev0); end
    bus_read(v, st, rel);
    checks++; if (v !== 8'h45) begin errors++; $display("[TB] FAIL read_value got=%h exp=45", v); end
    checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL read_stable got=%b exp=1", st); end
    checks++; if (rel !== 8'hFF) begin errors++; $display("[TB] FAIL read_release got=%h exp=ff", rel); end
    checks++; if (out_addr !== 8'h22) begin errors++; $display("[TB] FAIL addr_kept got=%h exp=22", out_addr); end
  endtask

  task automatic test_unmapped();
    int ev0;
    logic [7:0] v, rel;
    bit st;
    ev0 = ev_cnt;
    set_addr(8'h30);
    write_data(8'h5A);
    checks++; if (ev_cnt - ev0 !== 0) begin errors++; $display("[TB] FAIL unmapped_event got=%0d exp=0", ev_cnt - ev0); end
    bus_read(v, st, rel);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL unmapped_read got=%h exp=00", v); end
    ev0 = ev_cnt;
    set_addr(8'h00);
    write_data(8'h77);
    checks++; if (ev_cnt - ev0 !== 0) begin errors++; $display("[TB] FAIL status_event got=%0d exp=0", ev_cnt - ev0); end
    bus_read(v, st, rel);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL status_read got=%h exp=00", v); end
  endtask

  task automatic test_timer_regs();
    logic [7:0] ta [3];
    logic [7:0] tv [3];
    logic [7:0] v;
    ta = '{8'h41, 8'h42, 8'h43};
    tv = '{8'h12, 8'h34, 8'h56};
    for (int i = 0; i < 3; i++) begin
      set_addr(ta[i]);
      write_data(tv[i]);
    end
    for (int i = 0; i < 3; i++) begin
      read_reg(ta[i], v);
      checks++; if (v !== tv[i]) begin errors++; $display("[TB] FAIL timer_reg_%h got=%h exp=%h", ta[i], v, tv[i]); end
    end
  endtask

  task automatic test_protocol_error();
    int ev0, er0;
    bit bus_ok;
    logic [7:0] v;
    set_addr(8'h41);
    ev0 = ev_cnt; er0 = err_cnt; bus_ok = 1'b1;
    cs = 1'b0; a_d = 1'b1; rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dato !== 8'hFF) bus_ok = 1'b0;
    end
    rd = 1'b1;
    repeat (2) @(negedge clk);
    wr = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b1; a_d = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_ok !== 1'b1) begin errors++; $display("[TB] FAIL error_bus_released got=%b exp=1", bus_ok); end
    checks++; if (err_cnt - er0 !== 1) begin errors++; $display("[TB] FAIL error_pulse_count got=%0d exp=1", err_cnt - er0); end
    checks++; if (ev_cnt - ev0 !== 0) begin errors++; $display("[TB] FAIL error_no_event got=%0d exp=0", ev_cnt - ev0); end
    read_reg(8'h41, v);
    checks++; if (v !== 8'h12) begin errors++; $display("[TB] FAIL error_reg_kept got=%h exp=12", v); end
  endtask

  task automatic test_cs_ignored();
    int ev0;
    bit ok_cs, ok_ad;
    logic [7:0] v;
    ev0 = ev_cnt; ok_cs = 1'b1; ok_ad = 1'b1;
    cs = 1'b1; a_d = 1'b1; tb_dato = 8'h99; tb_drive = 1'b1; wr = 1'b0;
    repeat (5) @(negedge clk);
    wr = 1'b1;
    repeat (3) @(negedge clk);
    tb_drive = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dato !== 8'hFF) ok_cs = 1'b0;
    end
    rd = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b0; a_d = 1'b0; rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dato !== 8'hFF) ok_ad = 1'b0;
    end
    rd = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ev_cnt - ev0 !== 0) begin errors++; $display("[TB] FAIL cs_high_event got=%0d exp=0", ev_cnt - ev0); end
    checks++; if (ok_cs !== 1'b1) begin errors++; $display("[TB] FAIL cs_high_read_drive got=%b exp=1", ok_cs); end
    checks++; if (ok_ad !== 1'b1) begin errors++; $display("[TB] FAIL addr_phase_read_drive got=%b exp=1", ok_ad); end
    read_reg(8'h41, v);
    checks++; if (v !== 8'h12) begin errors++; $display("[TB] FAIL cs_high_reg_kept got=%h exp=12", v); end
  endtask

  task automatic test_reset_mid_strobe();
    int ev0;
    logic [7:0] seen;
    cs = 1'b0; a_d = 1'b0; tb_dato = 8'h42; tb_drive = 1'b1; wr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    checks++; if (out_addr !== 8'h00) begin errors++; $display("[TB] FAIL async_reset_addr got=%h exp=00", out_addr); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ev0 = ev_cnt;
    repeat (4) @(negedge clk);
    wr = 1'b1;
    repeat (5) @(negedge clk);
    cs = 1'b1; tb_drive = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_addr !== 8'h00) begin errors++; $display("[TB] FAIL stale_strobe_addr got=%h exp=00", out_addr); end
    checks++; if (ev_cnt - ev0 !== 0) begin errors++; $display("[TB] FAIL stale_strobe_event got=%0d exp=0", ev_cnt - ev0); end
    bus_write(1'b0, 8'h24, seen);
    checks++; if (seen !== 8'h24) begin errors++; $display("[TB] FAIL fresh_strobe_addr got=%h exp=24", seen); end
  endtask

  task automatic test_rollover();
    logic [7:0] v, rel;
    bit st;
    set_addr(8'h23); write_data(8'h23);
    set_addr(8'h22); write_data(8'h59);
    set_addr(8'h24); write_data(8'h15);
    set_addr(8'h25); write_data(8'h07);
    set_addr(8'h26); write_data(8'h24);
    set_addr(8'h21);
    wait_phase(0);
    write_data(8'h59);
    wait_phase(1);
    bus_read(v, st, rel);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rollover_sec got=%h exp=00", v); end
    read_reg(8'h22, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rollover_min got=%h exp=00", v); end
    read_reg(8'h23, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL rollover_hour got=%h exp=00", v); end
    read_reg(8'h24, v);
    checks++; if (v !== 8'h15) begin errors++; $display("[TB] FAIL day_kept got=%h exp=15", v); end
    read_reg(8'h25, v);
    checks++; if (v !== 8'h07) begin errors++; $display("[TB] FAIL month_kept got=%h exp=07", v); end
    read_reg(8'h26, v);
    checks++; if (v !== 8'h24) begin errors++; $display("[TB] FAIL year_kept got=%h exp=24", v); end
  endtask

  task automatic test_tick_collision();
    logic [7:0] v, rel;
    bit st;
    set_addr(8'h21);
    wait_phase(0);
    write_data(8'h59);
    wait_phase(TD - 8);
    write_data(8'h30);
    bus_read(v, st, rel);
    checks++; if (v !== 8'h30) begin errors++; $display("[TB] FAIL collision_sec got=%h exp=30", v); end
    wait_phase(1);
    bus_read(v, st, rel);
    checks++; if (v !== 8'h31) begin errors++; $display("[TB] FAIL next_tick_sec got=%h exp=31", v); end
    read_reg(8'h22, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL collision_min got=%h exp=00", v); end
    set_addr(8'h21);
    wait_phase(0);
    write_data(8'h09);
    wait_phase(1);
    bus_read(v, st, rel);
    checks++; if (v !== 8'h10) begin errors++; $display("[TB] FAIL bcd_carry_sec got=%h exp=10", v); end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_data_write_read();
    test_unmapped();
    test_timer_regs();
    test_protocol_error();
    test_cs_ignored();
    test_reset_mid_strobe();
    test_rollover();
    test_tick_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
